// File: rtl/jump_input_ctrl.sv
// Jump button front end: 2-FF sync, per-button debounce, one-shot jump pulse with lockout.
// A stable press yields its pulse DEBOUNCE_CYCLES+2 edges after the first sync stage samples it.
module jump_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 400000,
  parameter int unsigned LOCKOUT_CYCLES  = 8000000
) (
  input  logic clk,
  input  logic rst,
  input  logic module_en,
  input  logic btn_left,
  input  logic btn_right,
  output logic jump_left,
  output logic jump_right,
  output logic busy
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LO_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LO_W-1:0] LO_LAST = LO_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic {
    IDLE    = 1'b0,
    LOCKOUT = 1'b1
  } state_t;

  state_t          state_q;
  logic [LO_W-1:0] lock_cnt_q;
  logic            press_left;
  logic            press_right;

  jump_input_db #(
    .CYCLES (DEBOUNCE_CYCLES),
    .CNT_W  (DB_W)
  ) u_db_left (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_left),
    .press_o (press_left)
  );

  jump_input_db #(
    .CYCLES (DEBOUNCE_CYCLES),
    .CNT_W  (DB_W)
  ) u_db_right (
    .clk     (clk),
    .rst     (rst),
    .btn_i   (btn_right),
    .press_o (press_right)
  );

  // Presses arriving in LOCKOUT or while disabled are simply not looked at, so nothing queues.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      jump_left  <= 1'b0;
      jump_right <= 1'b0;
      busy       <= 1'b0;
    end else if (!module_en) begin
      state_q    <= IDLE;
      lock_cnt_q <= '0;
      jump_left  <= 1'b0;
      jump_right <= 1'b0;
      busy       <= 1'b0;
    end else begin
      jump_left  <= 1'b0;
      jump_right <= 1'b0;
      case (state_q)
        IDLE: begin
          if (press_left) begin
            jump_left  <= 1'b1;
            busy       <= 1'b1;
            lock_cnt_q <= '0;
            state_q    <= LOCKOUT;
          end else if (press_right) begin
            jump_right <= 1'b1;
            busy       <= 1'b1;
            lock_cnt_q <= '0;
            state_q    <= LOCKOUT;
          end
        end
        LOCKOUT: begin
          if (lock_cnt_q == LO_LAST) begin
            busy       <= 1'b0;
            lock_cnt_q <= '0;
            state_q    <= IDLE;
          end else begin
            lock_cnt_q <= lock_cnt_q + LO_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// Per-button synchroniser, debouncer and rising-edge detector.
// press_o is combinational from registered state, high for one cycle after db_q rises.
module jump_input_db #(
  parameter int unsigned CYCLES = 4,
  parameter int unsigned CNT_W  = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             db_q;
  logic             db_d;
  logic             db_dly_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Counter only advances while the synced input disagrees; any agreement restarts it.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = db_q & ~db_dly_q;

endmodule

// File: tb/tb_jump_input_ctrl.sv
// Scoreboard bench for jump_input_ctrl with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10.
// Stimulus pushes expected output events (kind, cycle); a negedge monitor pops and compares.
module tb_jump_input_ctrl;

  localparam int EV_JL   = 0;
  localparam int EV_JR   = 1;
  localparam int EV_RISE = 2;
  localparam int EV_FALL = 3;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic module_en = 1'b1;
  logic btn_left = 1'b0;
  logic btn_right = 1'b0;
  logic jump_left;
  logic jump_right;
  logic busy;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  logic busy_prev = 1'b0;
  ev_t exp_q[$];

  jump_input_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .LOCKOUT_CYCLES  (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .module_en  (module_en),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .jump_left  (jump_left),
    .jump_right (jump_right),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ev_name(input int k);
    case (k)
      EV_JL:   return "jump_left";
      EV_JR:   return "jump_right";
      EV_RISE: return "busy_rise";
      default: return "busy_fall";
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Button change made at cycle n is first sampled at edge n+1, so the pulse lands at edge n+7.
  task automatic exp_jump(input int kind, input int n, input int fall_at);
    exp_q.push_back('{kind: kind, cyc: n + 7});
    exp_q.push_back('{kind: EV_RISE, cyc: n + 7});
    exp_q.push_back('{kind: EV_FALL, cyc: fall_at});
  endtask

  task automatic got_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s at cycle %0d, required none", ev_name(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        errors++;
        $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                 ev_name(kind), cyc, ev_name(e.kind), e.cyc);
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (jump_left !== 1'b0 || jump_right !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: got jl=%b jr=%b busy=%b, required all 0", tag, jump_left, jump_right, busy);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0) begin
      checks++;
      if (jump_left === 1'b1 && jump_right === 1'b1) begin
        errors++;
        $display("FAIL exclusive: got jl=1 jr=1 at cycle %0d, required at most one", cyc);
      end
      if (jump_left === 1'b1) got_event(EV_JL);
      if (jump_right === 1'b1) got_event(EV_JR);
      if (busy === 1'b1 && busy_prev === 1'b0) got_event(EV_RISE);
      if (busy === 1'b0 && busy_prev === 1'b1) got_event(EV_FALL);
      busy_prev = busy;
    end
  end

  initial begin
    int n;
    int m;

    // 1: reset, then a quiet idle stretch
    repeat (3) begin
      tick(1);
      check_idle_outputs("reset_state");
    end
    rst = 1'b0;
    tick(50);
    check_idle_outputs("idle_quiet");

    // 2: held left press, one pulse only
    n = cyc;
    btn_left = 1'b1;
    exp_jump(EV_JL, n, n + 17);
    tick(40);
    btn_left = 1'b0;
    tick(10);

    // 3: 3-cycle right glitch is filtered, then a clean right press
    btn_right = 1'b1;
    tick(3);
    btn_right = 1'b0;
    tick(10);
    m = cyc;
    btn_right = 1'b1;
    exp_jump(EV_JR, m, m + 17);
    tick(20);
    btn_right = 1'b0;
    tick(10);

    // 4: simultaneous press -> left wins; right re-press inside lockout dropped
    n = cyc;
    btn_left  = 1'b1;
    btn_right = 1'b1;
    exp_jump(EV_JL, n, n + 17);
    tick(6);
    btn_right = 1'b0;
    tick(4);
    btn_right = 1'b1;
    tick(10);
    btn_right = 1'b0;
    tick(10);
    m = cyc;
    btn_right = 1'b1;
    exp_jump(EV_JR, m, m + 17);
    tick(20);
    btn_left  = 1'b0;
    btn_right = 1'b0;
    tick(10);

    // 5: press while disabled is discarded; disable mid-lockout clears busy next edge
    module_en = 1'b0;
    btn_left  = 1'b1;
    tick(12);
    module_en = 1'b1;
    tick(10);
    btn_left = 1'b0;
    tick(10);
    m = cyc;
    btn_left = 1'b1;
    exp_jump(EV_JL, m, m + 11);
    tick(10);
    module_en = 1'b0;
    tick(2);
    module_en = 1'b1;
    tick(10);
    btn_left = 1'b0;
    tick(10);

    // 6: reset inside lockout, then a fresh press with full latency
    n = cyc;
    btn_left = 1'b1;
    exp_jump(EV_JL, n, n + 10);
    tick(9);
    rst      = 1'b1;
    btn_left = 1'b0;
    tick(1);
    check_idle_outputs("reset_mid_lockout");
    rst = 1'b0;
    tick(10);
    m = cyc;
    btn_left = 1'b1;
    exp_jump(EV_JL, m, m + 17);
    tick(20);
    btn_left = 1'b0;
    tick(15);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d events still pending, required 0 (next %s at cycle %0d)",
               exp_q.size(), ev_name(exp_q[0].kind), exp_q[0].cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
